branch_resolve: RTL
===================

Name: branch_resolve

Overview:
- EX-stage branch resolution unit. It sits directly downstream of the opcode branch decoder.
- It consumes the decoder's one-hot branch-class vector, the override_rt flag and the constant rt_val, together with the register-file operands, the branch PC and the immediate.
- It evaluates the branch condition, computes the target, and drives a registered redirect to fetch plus a multi-cycle flush to the front end.
- It is a small FSM that accepts one branch at a time through a valid/ready handshake.

Parameters:
- FLUSH_CYCLES, 2, number of consecutive cycles flush stays high after a taken branch; legal range 1..15.
- CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  ID stage presents a decoded instruction.
- in_ready  out  1  unit can accept this cycle.
- is_branch  in  6  one-hot branch class: bit0 BEQ, bit1 BNE, bit2 BLEZ, bit3 BGTZ, bit4 BLTZ, bit5 BGEZ; 0 means not a branch.
- override_rt  in  1  when 1, compare operand B is rt_val instead of rt_data.
- rt_val  in  32  constant compare operand from the decoder.
- rs_data  in  32  register-file rs value.
- rt_data  in  32  register-file rt value.
- pc  in  32  PC of the branch instruction.
- imm16  in  16  branch offset in words.
- redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc.
- redirect_pc  out  32  branch target.
- flush  out  1  squash younger instructions.
- resolved  out  1  one-cycle pulse when any branch finishes evaluation.
- taken  out  1  outcome; valid only while resolved=1.
- illegal  out  1  one-cycle pulse when is_branch is multi-hot.

Behaviour:
- Reset (asynchronous, any time, including mid-FLUSH):
  - State goes to IDLE.
  - All outputs go to 0, except in_ready=1.
  - redirect_pc=32'h0.
  - Flush counter is cleared.
- States: IDLE, RESOLVE, FLUSH.
- in_ready = (state==IDLE). The handshake fires on in_valid & in_ready at a rising edge.
- IDLE, on handshake:
  - is_branch==0: consumed, no state change, no outputs.
  - is_branch one-hot: latch is_branch, A=rs_data, B=(override_rt ? rt_val : rt_data), pc, imm16; go to RESOLVE.
  - is_branch multi-hot (popcount>1): illegal pulses 1 cycle at the next edge; no redirect, no resolved; stay in IDLE.
- RESOLVE (exactly 1 cycle), conditions on latched operands, signed 32-bit:
  - BEQ: A==B.
  - BNE: A!=B.
  - BLEZ: A<=0.
  - BGTZ: A>0.
  - BLTZ: A<0.
  - BGEZ: A>=0.
  - B is ignored by BLEZ, BGTZ, BLTZ and BGEZ.
- Target = pc + 4 + (sign_extend(imm16) << 2), modulo 2^32 (wrap-around permitted, no error).
- At the RESOLVE exit edge:
  - resolved=1 and taken=cond, for 1 cycle.
  - If taken: redirect_valid=1 for 1 cycle, redirect_pc=target (held until the next taken branch), flush=1, counter loaded with FLUSH_CYCLES-1, next state FLUSH.
  - If not taken: redirect_pc is unchanged, next state IDLE.
- Latency: handshake at edge N, resolved/redirect visible after edge N+1.
- FLUSH:
  - flush stays 1. The counter decrements each cycle.
  - When the counter is 0, flush deasserts at the next edge and state returns to IDLE.
  - Total flush high time is FLUSH_CYCLES cycles, starting with the redirect cycle.
- in_valid during RESOLVE/FLUSH is ignored (in_ready=0). The upstream stage must hold its data.

Optional Feature:
- Macro: BRANCH_RESOLVE_STATS_EN.
- When defined:
  - Adds output ports stat_branches [CNT_W-1:0] and stat_taken [CNT_W-1:0].
  - They increment on each resolved pulse and each taken resolution respectively.
  - They saturate at all-ones and reset to 0.
  - Adds input stat_clear (1-bit, synchronous, zeroes both counters; clear wins over a simultaneous increment).
- When not defined: these ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- BEQ taken: rs_data=5, rt_data=5, override_rt=0, pc=32'h0000_1000, imm16=16'h0004 -> resolved=1, taken=1, redirect_valid 1 cycle, redirect_pc=32'h0000_1014, flush high 2 cycles, in_ready low 3 cycles.
- BNE not taken with override: rs_data=7, rt_data=9, override_rt=1, rt_val=7 -> resolved=1, taken=0, no redirect, no flush, in_ready back to 1 after 1 cycle.
- Signed compares: BLTZ with rs=32'hFFFF_FFFF -> taken. BGTZ with rs=0 -> not taken. BGEZ with rs=0 -> taken. BLEZ with rs=32'h8000_0000 -> taken.
- Negative offset and wrap: pc=32'h0000_0000, imm16=16'hFFFE -> redirect_pc=32'hFFFF_FFFC. is_branch=6'b000011 -> illegal pulse, no resolved/redirect.
- Reset mid-FLUSH (FLUSH_CYCLES=4, rst_n low in the 2nd flush cycle) -> flush=0 and in_ready=1 immediately, without waiting for a clock edge. The next branch resolves normally.
- With BRANCH_RESOLVE_STATS_EN: 3 branches, 2 taken -> stat_branches=3, stat_taken=2. stat_clear -> both 0.

Source files
------------

// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage branch condition/target unit with registered redirect and multi-cycle flush.
// Optional statistics counters enabled by defining BRANCH_RESOLVE_STATS_EN.
module branch_resolve #(
    parameter int FLUSH_CYCLES = 2
`ifdef BRANCH_RESOLVE_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  is_branch,
    input  logic        override_rt,
    input  logic [31:0] rt_val,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] pc,
    input  logic [15:0] imm16,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        resolved,
    output logic        taken,
    output logic        illegal
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    input  logic             stat_clear,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_taken
`endif
);
    typedef enum logic [1:0] {IDLE, RESOLVE, FLUSH} state_t;

    state_t      r_state, w_next;
    logic [5:0]  r_br, w_conds;
    logic [31:0] r_a, r_b, r_pc, r_redirect_pc, w_target;
    logic [15:0] r_imm;
    logic [3:0]  r_cnt;
    logic        r_redirect_valid, r_resolved, r_taken, r_illegal;
    logic        w_fire, w_onehot, w_multi, w_cond;

    assign in_ready       = r_state == IDLE;
    assign flush          = r_state == FLUSH;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign resolved       = r_resolved;
    assign taken          = r_taken;
    assign illegal        = r_illegal;

    always_comb begin
        w_fire   = in_valid & in_ready;
        w_multi  = (is_branch & (is_branch - 6'd1)) != 6'd0;
        w_onehot = (is_branch != 6'd0) & ~w_multi;
        // bit order matches is_branch: {BGEZ, BLTZ, BGTZ, BLEZ, BNE, BEQ}
        w_conds  = {~r_a[31], r_a[31], ~r_a[31] & (r_a != 32'd0), r_a[31] | (r_a == 32'd0),
                    r_a != r_b, r_a == r_b};
        w_cond   = |(r_br & w_conds);
        w_target = r_pc + 32'd4 + {{14{r_imm[15]}}, r_imm, 2'b00};
        w_next   = r_state;
        case (r_state)
            IDLE:    w_next = (w_fire & w_onehot) ? RESOLVE : IDLE;
            RESOLVE: w_next = w_cond ? FLUSH : IDLE;
            FLUSH:   w_next = (r_cnt == 4'd0) ? IDLE : FLUSH;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br             <= '0;
            r_a              <= '0;
            r_b              <= '0;
            r_pc             <= '0;
            r_imm            <= '0;
            r_cnt            <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_resolved       <= 1'b0;
            r_taken          <= 1'b0;
            r_illegal        <= 1'b0;
        end else begin
            r_redirect_valid <= 1'b0;
            r_resolved       <= 1'b0;
            r_taken          <= 1'b0;
            r_illegal        <= w_fire & w_multi;
            if (w_fire & w_onehot) begin
                r_br  <= is_branch;
                r_a   <= rs_data;
                r_b   <= override_rt ? rt_val : rt_data;
                r_pc  <= pc;
                r_imm <= imm16;
            end
            if (r_state == RESOLVE) begin
                r_resolved <= 1'b1;
                r_taken    <= w_cond;
                if (w_cond) begin
                    r_redirect_valid <= 1'b1;
                    r_redirect_pc    <= w_target;
                    r_cnt            <= 4'(FLUSH_CYCLES - 1);
                end
            end else if (r_state == FLUSH && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [CNT_W-1:0] r_stat_br, r_stat_tk;

    assign stat_branches = r_stat_br;
    assign stat_taken    = r_stat_tk;

    // clear takes priority over a same-cycle increment; counters saturate at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_br <= '0;
            r_stat_tk <= '0;
        end else if (stat_clear) begin
            r_stat_br <= '0;
            r_stat_tk <= '0;
        end else if (r_state == RESOLVE) begin
            if (~&r_stat_br)          r_stat_br <= r_stat_br + 1'b1;
            if (w_cond && ~&r_stat_tk) r_stat_tk <= r_stat_tk + 1'b1;
        end
    end
`endif
endmodule
